// File: rtl/sp_shift_unit_pkg.sv
// Shared types and constants for the sprite pixel engine.
// Optional sprite-0 hit logic is built when SP_ZERO_HIT_EN is defined.
package sp_shift_unit_pkg;

    // Sprite tiles are always 8 pixels wide.
    localparam int SPRITE_WIDTH = 8;

    // Attribute byte bit positions used by this engine. Vertical flip is
    // resolved during pattern fetch, before the bitmaps reach second OAM.
    localparam int ATTR_PRIO  = 5;
    localparam int ATTR_FLIPH = 6;

    // One second-OAM entry as handed over at the end of sprite fetch.
    typedef struct packed {
        logic       active;
        logic [7:0] x_pos;
        logic [7:0] attribute;
        logic [7:0] bitmap_hi;
        logic [7:0] bitmap_lo;
    } second_oam_t;

    // Mirror a bitmap row so a horizontally flipped sprite still shifts MSB-first.
    function automatic logic [SPRITE_WIDTH-1:0] bit_rev8(input logic [SPRITE_WIDTH-1:0] v);
        logic [SPRITE_WIDTH-1:0] r;
        for (int i = 0; i < SPRITE_WIDTH; i++) begin
            r[i] = v[SPRITE_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sp_shift_unit_slot.sv
// One sprite slot: X down-counter, latched palette/priority and the two
// pattern shift registers. Emits this dot's 2-bit pixel combinationally.
module sp_shift_unit_slot
    import sp_shift_unit_pkg::*;
#(
    parameter int PAL_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              pix_en_i,
    input  second_oam_t       entry_i,
    output logic [1:0]        pix_o,
    output logic [PAL_W-1:0]  pal_o,
    output logic              prio_o
);

    logic                    active_q, active_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [PAL_W-1:0]        pal_q, pal_d;
    logic                    prio_q, prio_d;
    logic [SPRITE_WIDTH-1:0] lo_sr_q, lo_sr_d;
    logic [SPRITE_WIDTH-1:0] hi_sr_q, hi_sr_d;

    // Only the palette, priority and flip bits of the attribute are consumed here.
    logic unused_attr;
    assign unused_attr = ^entry_i.attribute;

    // Next state: load wins over a dot advance; counter saturates at 0,
    // after which the pattern bits shift out with zero fill.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        pal_d    = pal_q;
        prio_d   = prio_q;
        lo_sr_d  = lo_sr_q;
        hi_sr_d  = hi_sr_q;
        if (load_i) begin
            active_d = entry_i.active;
            cnt_d    = entry_i.x_pos;
            pal_d    = entry_i.attribute[PAL_W-1:0];
            prio_d   = entry_i.attribute[ATTR_PRIO];
            if (!entry_i.active) begin
                lo_sr_d = '0;
                hi_sr_d = '0;
            end else if (entry_i.attribute[ATTR_FLIPH]) begin
                lo_sr_d = bit_rev8(entry_i.bitmap_lo);
                hi_sr_d = bit_rev8(entry_i.bitmap_hi);
            end else begin
                lo_sr_d = entry_i.bitmap_lo;
                hi_sr_d = entry_i.bitmap_hi;
            end
        end else if (pix_en_i) begin
            if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                lo_sr_d = {lo_sr_q[SPRITE_WIDTH-2:0], 1'b0};
                hi_sr_d = {hi_sr_q[SPRITE_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Slot state registers; reset leaves the slot inactive and empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= 8'd0;
            pal_q    <= '0;
            prio_q   <= 1'b0;
            lo_sr_q  <= '0;
            hi_sr_q  <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            pal_q    <= pal_d;
            prio_q   <= prio_d;
            lo_sr_q  <= lo_sr_d;
            hi_sr_q  <= hi_sr_d;
        end
    end

    // Pixel for the current dot: visible only once the counter has run out.
    always_comb begin
        pix_o = 2'b00;
        if (active_q && (cnt_q == 8'd0)) begin
            pix_o = {hi_sr_q[SPRITE_WIDTH-1], lo_sr_q[SPRITE_WIDTH-1]};
        end
    end

    assign pal_o  = pal_q;
    assign prio_o = prio_q;

endmodule

// File: rtl/sp_shift_unit.sv
// Sprite pixel engine top: NUM_SP slots, lowest-index opaque slot wins,
// left-column clip, registered pixel/priority/valid outputs.
// Define SP_ZERO_HIT_EN to add bg_opaque/sp0_hit_clr inputs and the sticky sp0_hit flag.
module sp_shift_unit
    import sp_shift_unit_pkg::*;
#(
    parameter int NUM_SP = 8,
    parameter int PAL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  second_oam_t       sec_oam [NUM_SP],
    input  logic              sp0_present,
    input  logic              pix_en,
    input  logic [8:0]        col,
    input  logic              clip_left,
`ifdef SP_ZERO_HIT_EN
    input  logic              bg_opaque,
    input  logic              sp0_hit_clr,
    output logic              sp0_hit,
`endif
    output logic [PAL_W+1:0]  sp_color_idx,
    output logic              sp_prio,
    output logic              sp_valid
);

    logic [1:0]       slot_pix  [NUM_SP];
    logic [PAL_W-1:0] slot_pal  [NUM_SP];
    logic [NUM_SP-1:0] slot_prio;

    genvar g;
    generate
        for (g = 0; g < NUM_SP; g++) begin : g_slot
            sp_shift_unit_slot #(
                .PAL_W (PAL_W)
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .load_i   (load),
                .pix_en_i (pix_en),
                .entry_i  (sec_oam[g]),
                .pix_o    (slot_pix[g]),
                .pal_o    (slot_pal[g]),
                .prio_o   (slot_prio[g])
            );
        end
    endgenerate

    // A dot advance only counts when no load is happening in the same cycle.
    logic dot_adv;
    assign dot_adv = pix_en && !load;

    // Dots hidden from sprites: clipped left margin and anything past column 255.
    logic dot_masked;
    assign dot_masked = (clip_left && (col < 9'd8)) || col[8];

    // Priority select: walk from the lowest-priority slot up so the
    // lowest-index opaque slot is the last (and winning) assignment.
    logic [1:0]       win_pix;
    logic [PAL_W-1:0] win_pal;
    logic             win_prio;
    always_comb begin
        win_pix  = 2'b00;
        win_pal  = '0;
        win_prio = 1'b0;
        for (int i = NUM_SP - 1; i >= 0; i--) begin
            if (slot_pix[i] != 2'b00) begin
                win_pix  = slot_pix[i];
                win_pal  = slot_pal[i];
                win_prio = slot_prio[i];
            end
        end
    end

    logic [PAL_W+1:0] color_q, color_d;
    logic             prio_q, prio_d;
    logic             valid_q, valid_d;

    // Output next state: update on a dot advance, otherwise hold.
    always_comb begin
        color_d = color_q;
        prio_d  = prio_q;
        valid_d = dot_adv;
        if (dot_adv) begin
            if (dot_masked || (win_pix == 2'b00)) begin
                color_d = '0;
                prio_d  = 1'b0;
            end else begin
                color_d = {win_pal, win_pix};
                prio_d  = win_prio;
            end
        end
    end

    // Registered pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= '0;
            prio_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            color_q <= color_d;
            prio_q  <= prio_d;
            valid_q <= valid_d;
        end
    end

    assign sp_color_idx = color_q;
    assign sp_prio      = prio_q;
    assign sp_valid     = valid_q;

`ifdef SP_ZERO_HIT_EN
    logic sp0_q, sp0_d;
    logic hit_q, hit_d;
    logic hit_set;

    // Sprite-0 hit uses slot 0's own pixel, whether or not it won the dot.
    assign hit_set = dot_adv && sp0_q && (slot_pix[0] != 2'b00) && bg_opaque
                     && (col != 9'd255) && !dot_masked;

    // Latch sp0_present per line; the hit flag is sticky and clear dominates.
    always_comb begin
        sp0_d = load ? sp0_present : sp0_q;
        hit_d = hit_q;
        if (sp0_hit_clr) begin
            hit_d = 1'b0;
        end else if (hit_set) begin
            hit_d = 1'b1;
        end
    end

    // Sprite-0 hit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp0_q <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            sp0_q <= sp0_d;
            hit_q <= hit_d;
        end
    end

    assign sp0_hit = hit_q;
`else
    logic unused_sp0;
    assign unused_sp0 = sp0_present;
`endif

endmodule

// File: tb/tb_sp_shift_unit.sv
// Self-checking bench for sp_shift_unit (also covers SP_ZERO_HIT_EN when defined).
module tb_sp_shift_unit;
    import sp_shift_unit_pkg::*;

    localparam int NUM_SP = 8;
    localparam int PAL_W  = 2;
    localparam int EW     = PAL_W + 3;   // {prio, color_idx}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              load = 1'b0;
    second_oam_t       sec_oam [NUM_SP];
    logic              sp0_present = 1'b0;
    logic              pix_en = 1'b0;
    logic [8:0]        col = '0;
    logic              clip_left = 1'b0;
    logic [PAL_W+1:0]  sp_color_idx;
    logic              sp_prio;
    logic              sp_valid;
`ifdef SP_ZERO_HIT_EN
    logic              bg_opaque = 1'b0;
    logic              sp0_hit_clr = 1'b0;
    logic              sp0_hit;
    logic              exp_hit = 1'b0;
`endif

    sp_shift_unit #(.NUM_SP(NUM_SP), .PAL_W(PAL_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .sec_oam      (sec_oam),
        .sp0_present  (sp0_present),
        .pix_en       (pix_en),
        .col          (col),
        .clip_left    (clip_left),
`ifdef SP_ZERO_HIT_EN
        .bg_opaque    (bg_opaque),
        .sp0_hit_clr  (sp0_hit_clr),
        .sp0_hit      (sp0_hit),
`endif
        .sp_color_idx (sp_color_idx),
        .sp_prio      (sp_prio),
        .sp_valid     (sp_valid)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp = '0;
    int n_checks = 0;
    int n_fail   = 0;

    second_oam_t tb_oam  [NUM_SP];
    second_oam_t ref_oam [NUM_SP];
    logic        tb_sp0   = 1'b0;
    logic        ref_sp0  = 1'b0;
    logic        ref_live = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: position-based lookup of a slot's pixel at a column,
    // assuming the line's dots start at column 0 right after the load.
    function automatic logic [1:0] ref_slot(input int s, input int c);
        second_oam_t e;
        int off;
        int idx;
        e   = ref_oam[s];
        off = c - int'(e.x_pos);
        if (!ref_live || !e.active || c > 255 || off < 0 || off > 7) return 2'b00;
        idx = e.attribute[6] ? off : 7 - off;
        return {e.bitmap_hi[idx], e.bitmap_lo[idx]};
    endfunction

    function automatic logic [EW-1:0] ref_pix(input int c);
        logic [1:0] p;
        if (clip_left && c < 8) return '0;
        for (int s = 0; s < NUM_SP; s++) begin
            p = ref_slot(s, c);
            if (p != 2'b00) return {ref_oam[s].attribute[5], ref_oam[s].attribute[PAL_W-1:0], p};
        end
        return '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_oam();
        for (int s = 0; s < NUM_SP; s++) tb_oam[s] = '0;
        tb_sp0 = 1'b0;
    endtask

    task automatic set_slot(input int s, input int x, input int attr, input int hi, input int lo);
        tb_oam[s].active    = 1'b1;
        tb_oam[s].x_pos     = x[7:0];
        tb_oam[s].attribute = attr[7:0];
        tb_oam[s].bitmap_hi = hi[7:0];
        tb_oam[s].bitmap_lo = lo[7:0];
    endtask

    // Load cycle, optionally with a colliding pix_en that must be dropped.
    task automatic do_load(input logic with_pix);
        @(negedge clk);
        load        = 1'b1;
        pix_en      = with_pix;
        col         = '0;
        sec_oam     = tb_oam;
        sp0_present = tb_sp0;
        @(posedge clk); #1;
        check_val("load_valid", {31'd0, sp_valid}, 32'd0);
        check_val("load_hold", {{(32-PAL_W-2){1'b0}}, sp_color_idx}, {{(32-PAL_W-2){1'b0}}, last_exp[PAL_W+1:0]});
        ref_oam  = tb_oam;
        ref_sp0  = tb_sp0;
        ref_live = 1'b1;
    endtask

    // One visible dot: push expected result, compare after the clock edge.
    task automatic dot(input int c);
        logic [EW-1:0] e;
        @(negedge clk);
        load   = 1'b0;
        pix_en = 1'b1;
        col    = c[8:0];
        exp_q.push_back(ref_pix(c));
`ifdef SP_ZERO_HIT_EN
        if (sp0_hit_clr) exp_hit = 1'b0;
        else if (ref_sp0 && ref_slot(0, c) != 2'b00 && bg_opaque && c != 255
                 && !(clip_left && c < 8)) exp_hit = 1'b1;
`endif
        @(posedge clk); #1;
        e = exp_q.pop_front();
        check_val("valid", {31'd0, sp_valid}, 32'd1);
        check_val($sformatf("color@%0d", c), {{(32-PAL_W-2){1'b0}}, sp_color_idx},
                  {{(32-PAL_W-2){1'b0}}, e[PAL_W+1:0]});
        check_val($sformatf("prio@%0d", c), {31'd0, sp_prio}, {31'd0, e[EW-1]});
`ifdef SP_ZERO_HIT_EN
        check_val($sformatf("hit@%0d", c), {31'd0, sp0_hit}, {31'd0, exp_hit});
`endif
        last_exp = e;
    endtask

    task automatic run_dots(input int c0, input int c1);
        for (int c = c0; c <= c1; c++) dot(c);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        load   = 1'b0;
        pix_en = 1'b0;
        @(posedge clk); #1;
        check_val("idle_valid", {31'd0, sp_valid}, 32'd0);
        check_val("idle_hold", {{(32-PAL_W-2){1'b0}}, sp_color_idx}, {{(32-PAL_W-2){1'b0}}, last_exp[PAL_W+1:0]});
    endtask

    task automatic after_reset_model();
        ref_live = 1'b0;
        ref_sp0  = 1'b0;
        last_exp = '0;
`ifdef SP_ZERO_HIT_EN
        exp_hit = 1'b0;
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_oam();
        sec_oam = tb_oam;

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load   = 1'($urandom_range(0, 1));
            pix_en = 1'($urandom_range(0, 1));
            col    = 9'($urandom_range(0, 300));
            for (int s = 0; s < NUM_SP; s++) sec_oam[s] = second_oam_t'({$urandom, $urandom});
        end
        #1;
        check_val("rst_color", {{(32-PAL_W-2){1'b0}}, sp_color_idx}, 32'd0);
        check_val("rst_valid", {31'd0, sp_valid}, 32'd0);
        check_val("rst_prio", {31'd0, sp_prio}, 32'd0);
        @(negedge clk);
        load = 1'b0; pix_en = 1'b0; col = '0;
        sec_oam = tb_oam;
        rst_n = 1'b1;
        after_reset_model();
        run_dots(0, 3);
        idle_cycle();

        // Basic: single sprite, one pixel at col 10.
        clear_oam();
        set_slot(0, 10, 8'h01, 8'h00, 8'h80);
        do_load(1'b0);
        run_dots(0, 9);
        dot(10);
        check_val("basic_c10", {{(32-PAL_W-2){1'b0}}, sp_color_idx}, 32'b0101);
        run_dots(11, 17);
        idle_cycle();

        // Flip and overlap: transparent slot 0 yields to slot 1.
        clear_oam();
        set_slot(0, 20, 8'h40, 8'h00, 8'h01);
        set_slot(1, 20, 8'h23, 8'hFF, 8'hFF);
        do_load(1'b0);
        run_dots(0, 20);
        check_val("flip_c20", {{(32-PAL_W-2){1'b0}}, sp_color_idx}, 32'b0001);
        check_val("flip_c20_prio", {31'd0, sp_prio}, 32'd0);
        dot(21);
        check_val("ovl_c21", {{(32-PAL_W-2){1'b0}}, sp_color_idx}, 32'b1111);
        check_val("ovl_c21_prio", {31'd0, sp_prio}, 32'd1);
        run_dots(22, 30);

        // Edge: x=255 visible only at col 255, nothing beyond.
        clear_oam();
        set_slot(0, 255, 8'h00, 8'h00, 8'hFF);
        do_load(1'b0);
        run_dots(0, 255);
        check_val("x255_c255", {{(32-PAL_W-2){1'b0}}, sp_color_idx}, 32'b0001);
        run_dots(256, 258);

        // Left clip: x=0 sprite hidden for cols 0..7.
        clear_oam();
        set_slot(0, 0, 8'h02, 8'h00, 8'hFF);
        clip_left = 1'b1;
        do_load(1'b0);
        run_dots(0, 10);
        clip_left = 1'b0;

        // Collision: load with pix_en in the same cycle must not shift.
        clear_oam();
        set_slot(0, 0, 8'h00, 8'h00, 8'h80);
        do_load(1'b1);
        dot(0);
        check_val("coll_c0", {{(32-PAL_W-2){1'b0}}, sp_color_idx}, 32'b0001);
        run_dots(1, 3);

        // Random lines.
        for (int r = 0; r < 3; r++) begin
            clear_oam();
            for (int s = 0; s < NUM_SP; s++) begin
                if ($urandom_range(0, 3) != 0)
                    set_slot(s, $urandom_range(0, 40), $urandom_range(0, 255),
                             $urandom_range(0, 255), $urandom_range(0, 255));
            end
            tb_sp0 = 1'($urandom_range(0, 1));
            clip_left = 1'($urandom_range(0, 1));
`ifdef SP_ZERO_HIT_EN
            bg_opaque = 1'($urandom_range(0, 1));
`endif
            do_load(1'b0);
            run_dots(0, 50);
            idle_cycle();
        end
        clip_left = 1'b0;

        // Reset asserted mid-line at col 14.
        clear_oam();
        set_slot(0, 10, 8'h02, 8'hFF, 8'hFF);
        do_load(1'b0);
        run_dots(0, 13);
        @(negedge clk);
        pix_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_color", {{(32-PAL_W-2){1'b0}}, sp_color_idx}, 32'd0);
        check_val("midrst_valid", {31'd0, sp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        after_reset_model();
        run_dots(14, 20);

`ifdef SP_ZERO_HIT_EN
        // Clear any sticky hit left by random lines.
        @(negedge clk);
        sp0_hit_clr = 1'b1; pix_en = 1'b0;
        @(posedge clk); #1;
        exp_hit = 1'b0;
        check_val("hit_clr", {31'd0, sp0_hit}, 32'd0);
        @(negedge clk);
        sp0_hit_clr = 1'b0;

        // Hit at col 30, sticky afterwards.
        clear_oam();
        set_slot(0, 30, 8'h00, 8'h00, 8'h80);
        tb_sp0 = 1'b1;
        bg_opaque = 1'b1;
        do_load(1'b0);
        run_dots(0, 29);
        check_val("hit_before", {31'd0, sp0_hit}, 32'd0);
        dot(30);
        check_val("hit_c30", {31'd0, sp0_hit}, 32'd1);
        run_dots(31, 35);
        check_val("hit_sticky", {31'd0, sp0_hit}, 32'd1);

        @(negedge clk);
        sp0_hit_clr = 1'b1; pix_en = 1'b0;
        @(posedge clk); #1;
        exp_hit = 1'b0;
        @(negedge clk);
        sp0_hit_clr = 1'b0;

        // No hit at col 255.
        clear_oam();
        set_slot(0, 255, 8'h00, 8'h00, 8'hFF);
        tb_sp0 = 1'b1;
        do_load(1'b0);
        run_dots(0, 258);
        check_val("hit_c255", {31'd0, sp0_hit}, 32'd0);

        // Clear wins over a simultaneous set.
        clear_oam();
        set_slot(0, 5, 8'h00, 8'h00, 8'h80);
        tb_sp0 = 1'b1;
        do_load(1'b0);
        run_dots(0, 4);
        sp0_hit_clr = 1'b1;
        dot(5);
        sp0_hit_clr = 1'b0;
        check_val("hit_clr_wins", {31'd0, sp0_hit}, 32'd0);
        run_dots(6, 8);
        bg_opaque = 1'b0;
`endif

        if (exp_q.size() != 0) check_val("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sp_shift_unit.md
Name: sp_shift_unit

Overview:
- Sequential, parametrised sprite pixel engine for the PPU render pipeline; the successor to the combinational per-dot sprite pixel lookup.
- At the end of each scanline's sprite fetch it loads NUM_SP second-OAM entries into per-slot X down-counters, attribute latches and pattern shift registers.
- On each visible dot it emits one registered sprite pixel, resolved by NES priority: the lowest-index *opaque* slot wins, not the first in-range slot.
- Feeds the pixel mux (with sp_prio) and the PPUSTATUS logic.

Parameters:
- NUM_SP, 8, number of sprite slots (1..64); slot 0 has highest priority.
- PAL_W, 2, palette-select width taken from attribute[PAL_W-1:0].

Ports:
- clk  in  1  PPU dot clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  one-cycle strobe; latch all sec_oam slots
- sec_oam  in  second_oam_t[NUM_SP]  second-OAM entries (active, x_pos[7:0], attribute[7:0], bitmap_hi/lo[7:0])
- sp0_present  in  1  slot 0 holds OAM sprite 0 this line (latched on load)
- pix_en  in  1  advance one visible dot
- col  in  9  current dot column (for left clip)
- clip_left  in  1  PPUMASK bit 2 inverted: hide sprites at col<8
- sp_color_idx  out  PAL_W+2  {pal_idx, color_idx}; 0 means transparent
- sp_prio  out  1  attribute[5] of the winning slot (1 = behind background)
- sp_valid  out  1  registered pixel corresponds to the previous pix_en

Behaviour:
- Reset (async, rst_n=0): all slots inactive; counters, shift registers and outputs are 0; sp_valid=0.
- On load:
  - Each slot captures active, cnt=x_pos, pal, prio.
  - lo_sr/hi_sr capture the bitmaps, bit-reversed when attribute[6]=1 (horizontal flip), so shifting is always MSB-first.
  - Inactive slots load sr=0.
  - load has priority over a simultaneous pix_en; that pix_en is dropped and sp_valid stays 0 next cycle.
- On pix_en, per slot:
  - cnt!=0: cnt decrements and the slot is transparent this dot.
  - cnt==0: the slot pixel is {hi_sr[7], lo_sr[7]}; both registers shift left with 0 fill.
  - After 8 shifts the slot is permanently transparent; no extra state is needed.
  - x_pos=255 yields exactly one pixel, at col 255. Columns beyond 255 are transparent.
- Priority resolution: scan slots 0..NUM_SP-1 and select the first active slot with a non-zero 2-bit pixel. If none qualifies, output 0 with sp_prio=0.
- Clip: if clip_left=1 and col<8, the resolved pixel is forced transparent. Counters and shift registers still advance.
- Latency: outputs are registered, valid 1 cycle after pix_en. sp_valid=pix_en delayed 1 (and not load). Outputs hold their value when pix_en=0.
- Reset asserted mid-line: immediate clear; no pixels until the next load.
- Width rules: cnt is 8 bit and never underflows (held at 0). Priority-encoder depth is log2(NUM_SP).

Optional Feature:
- Macro: SP_ZERO_HIT_EN.
- Enabled:
  - Adds input bg_opaque (1) and output sp0_hit (1, sticky).
  - sp0_hit sets on a pix_en cycle where sp0_present (latched) is 1, slot 0's own pixel is opaque, bg_opaque=1, col!=255, and the dot is not clip-masked.
  - The slot-0 condition holds even if slot 0 is not the winning slot.
  - Cleared by rst_n or by new input sp0_hit_clr (1). Clear wins over a simultaneous set.
- Disabled: neither port exists; no hit logic.

Decomposition:
- ppu_pkg / ppu_defines.vh: second_oam_t, SPRITE_WIDTH, attribute bit indices (ATTR_PRIO=5, ATTR_FLIPH=6, ATTR_FLIPV=7).
- Sub-module sp_slot (one per slot, generate loop): holds the counter, shift registers and latched attributes. It outputs pix[1:0], pal and prio.
- The top level holds the priority encoder, clip logic and output registers.

Test Plan:
- Reset/idle: hold rst_n=0 with random inputs -> sp_color_idx=0, sp_valid=0. Release and pulse pix_en with no load -> outputs 0.
- Basic: slot0 x=10, lo=0x80, hi=0x00, attr=0x01, load, then pix_en for cols 0..17 -> sp_color_idx=4'b0101 at col 10 only, registered one cycle after that pix_en; 0 elsewhere.
- Flip and overlap:
  - slot0 x=20, lo=0x01, attr=0x40 (flip); slot1 x=20, lo=0xFF, hi=0xFF, attr=0x23.
  - col 20 -> 4'b0001 from slot0, prio=0.
  - col 21..27 -> 4'b1111, prio=1 (transparent slot0 yields to slot1).
- Edge: x=255, lo=0xFF -> opaque only at col 255. clip_left=1 with x=0, lo=0xFF -> cols 0..7 transparent.
- Collision: load and pix_en in the same cycle -> no shift, sp_valid=0. Assert rst_n=0 at col 14 of an active sprite -> next pixels 0.
- SP_ZERO_HIT_EN:
  - slot0 opaque at col 30, sp0_present=1, bg_opaque=1 -> sp0_hit=1 after col 30 and stays 1.
  - At col 255 -> no hit.
  - sp0_hit_clr asserted together with a hit -> sp0_hit=0.
